// File: rtl/ahb_uart_top.sv
`timescale 1ns/1ps
// AHB-style UART slave: CTRL register (scanf flag, bit 0) and DATA register.
// Words travel as 34-bit serial frames: start bit, 32 data bits LSB first, stop bit.
module ahb_uart_top #(
   parameter int unsigned CLK_FRE        = 50,
   parameter int unsigned BAUD_RATE      = 115200,
   parameter int unsigned AHB_ADDR_WIDTH = 32,
   parameter int unsigned AHB_DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      hsel,
   input  logic                      hwrite,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [AHB_DATA_WIDTH-1:0] hwdata,
   output logic                      hready,
   output logic                      hresp,
   output logic [AHB_DATA_WIDTH-1:0] hrdata,
   input  logic                      rx_pin,
   output logic                      tx_pin
);
   localparam int unsigned DW    = AHB_DATA_WIDTH;
   localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int unsigned CW    = $clog2(CYCLE + 1);
   localparam int unsigned IW    = $clog2(DW + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CYCLE / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_WAIT_TX, S_WAIT_RX, S_DONE
   } bus_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   bus_state_t      bus_q, bus_d;
   logic            write_q, write_d;
   logic            ctrl_q, ctrl_d;
   logic            resp_q, resp_d;
   logic            scanf_q, scanf_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [DW-1:0]   txbuf_q, txbuf_d;

   logic            tx_load;
   logic [DW-1:0]   tx_word;
   logic            tx_busy_q, tx_busy_d;
   logic [DW+1:0]   tx_frame_q, tx_frame_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [IW-1:0]   tx_idx_q, tx_idx_d;

   rx_state_t       rx_st_q, rx_st_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [IW-1:0]   rx_idx_q, rx_idx_d;
   logic [DW-1:0]   rx_shift_q, rx_shift_d;
   logic [DW-1:0]   rx_word_q, rx_word_d;
   logic            rx_valid_q, rx_valid_d;
   logic            rx_prev_q, rx_prev_d;

   logic            unused_haddr;
   assign unused_haddr = ^haddr[AHB_ADDR_WIDTH-5:0];

   always_comb begin
      bus_d   = bus_q;
      write_d = write_q;
      ctrl_d  = ctrl_q;
      resp_d  = 1'b0;
      scanf_d = scanf_q;
      rdata_d = rdata_q;
      txbuf_d = txbuf_q;
      tx_load = 1'b0;
      tx_word = hwdata;
      case (bus_q)
         S_IDLE: begin
            if (hsel) begin
               write_d = hwrite;
               bus_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            case (haddr[AHB_ADDR_WIDTH-1 -: 4])
               4'h7: begin
                  ctrl_d = 1'b1;
                  if (write_q) begin
                     bus_d = S_DATA;
                  end else begin
                     rdata_d    = '0;
                     rdata_d[0] = scanf_q;
                     bus_d      = S_DONE;
                  end
               end
               4'h3: begin
                  ctrl_d = 1'b0;
                  bus_d  = S_DATA;
               end
               default: begin
                  resp_d = 1'b1;
                  bus_d  = S_DONE;
               end
            endcase
         end
         S_DATA: begin
            if (ctrl_q) begin
               scanf_d = hwdata[0];
               bus_d   = S_DONE;
            end else if (write_q) begin
               if (!tx_busy_q) begin
                  tx_load = 1'b1;
                  bus_d   = S_DONE;
               end else begin
                  txbuf_d = hwdata;
                  bus_d   = S_WAIT_TX;
               end
            end else if (scanf_q) begin
               bus_d = S_WAIT_RX;
            end else begin
               rdata_d = rx_word_q;
               bus_d   = S_DONE;
            end
         end
         S_WAIT_TX: begin
            if (!tx_busy_q) begin
               tx_load = 1'b1;
               tx_word = txbuf_q;
               bus_d   = S_DONE;
            end
         end
         S_WAIT_RX: begin
            if (rx_valid_q) begin
               rdata_d = rx_word_q;
               bus_d   = S_DONE;
            end
         end
         default: bus_d = S_IDLE;
      endcase
   end

   // TX: frame register shifts right once per bit time; bit 0 drives the line.
   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_frame_d = tx_frame_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      if (tx_load) begin
         tx_busy_d  = 1'b1;
         tx_frame_d = {1'b1, tx_word, 1'b0};
         tx_cnt_d   = '0;
         tx_idx_d   = '0;
      end else if (tx_busy_q) begin
         if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_d = '0;
            if (tx_idx_q == IW'(DW + 1)) begin
               tx_busy_d = 1'b0;
            end else begin
               tx_frame_d = {1'b1, tx_frame_q[DW+1:1]};
               tx_idx_d   = tx_idx_q + IW'(1);
            end
         end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
         end
      end
   end

   // RX: start bit re-checked at half a bit time, later bits sampled mid-bit.
   always_comb begin
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_word_d  = rx_word_q;
      rx_valid_d = 1'b0;
      rx_prev_d  = rx_pin;
      if (!scanf_q) begin
         rx_st_d = R_IDLE;
      end else begin
         case (rx_st_q)
            R_IDLE: begin
               if (rx_prev_q && !rx_pin) begin
                  rx_st_d  = R_START;
                  rx_cnt_d = '0;
               end
            end
            R_START: begin
               if (rx_cnt_q == CNT_HALF) begin
                  rx_cnt_d = '0;
                  rx_idx_d = '0;
                  rx_st_d  = rx_pin ? R_IDLE : R_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + CW'(1);
               end
            end
            R_DATA: begin
               if (rx_cnt_q == CNT_LAST) begin
                  rx_cnt_d   = '0;
                  rx_shift_d = {rx_pin, rx_shift_q[DW-1:1]};
                  if (rx_idx_q == IW'(DW - 1)) begin
                     rx_st_d = R_STOP;
                  end else begin
                     rx_idx_d = rx_idx_q + IW'(1);
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + CW'(1);
               end
            end
            R_STOP: begin
               if (rx_cnt_q == CNT_LAST) begin
                  rx_st_d = R_IDLE;
                  if (rx_pin) begin
                     rx_word_d  = rx_shift_q;
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + CW'(1);
               end
            end
            default: rx_st_d = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         bus_q   <= S_IDLE;
         write_q <= 1'b0;
         ctrl_q  <= 1'b0;
         resp_q  <= 1'b0;
         scanf_q <= 1'b0;
         rdata_q <= '0;
         txbuf_q <= '0;
      end else begin
         bus_q   <= bus_d;
         write_q <= write_d;
         ctrl_q  <= ctrl_d;
         resp_q  <= resp_d;
         scanf_q <= scanf_d;
         rdata_q <= rdata_d;
         txbuf_q <= txbuf_d;
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         tx_busy_q  <= 1'b0;
         tx_frame_q <= '1;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
      end else begin
         tx_busy_q  <= tx_busy_d;
         tx_frame_q <= tx_frame_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         rx_st_q    <= R_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_word_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_prev_q  <= 1'b1;
      end else begin
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_word_q  <= rx_word_d;
         rx_valid_q <= rx_valid_d;
         rx_prev_q  <= rx_prev_d;
      end
   end

   assign hready = !(bus_q inside {S_DATA, S_WAIT_TX, S_WAIT_RX});
   assign hresp  = resp_q;
   assign hrdata = rdata_q;
   assign tx_pin = tx_busy_q ? tx_frame_q[0] : 1'b1;

endmodule

// File: tb/tb_ahb_uart_top.sv
`timescale 1ns/1ps
// Directed/randomized bench for ahb_uart_top; expectations come from a small
// register/serial-line model of the peripheral.
module tb_ahb_uart_top;
   localparam int unsigned CLK_FRE   = 1;
   localparam int unsigned BAUD_RATE = 100000;
   localparam int unsigned CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int unsigned HALF      = CYCLE / 2;
   localparam int unsigned FRAME     = 34 * CYCLE;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        hsel = 1'b0;
   logic        hwrite = 1'b0;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic        rx_pin = 1'b1;
   logic        hready, hresp, tx_pin;
   logic [31:0] hrdata;

   int unsigned passed = 0;
   int unsigned failed = 0;
   int unsigned total  = 0;

   logic        model_scanf  = 1'b0;
   logic [31:0] model_last_rx = '0;
   logic [31:0] model_hrdata  = '0;

   logic [31:0] rx_rd;
   logic        rx_rs;
   int unsigned rx_lat;
   logic [31:0] w_a, w_b, w_rx2;

   ahb_uart_top #(
      .CLK_FRE(CLK_FRE),
      .BAUD_RATE(BAUD_RATE),
      .AHB_ADDR_WIDTH(32),
      .AHB_DATA_WIDTH(32)
   ) dut (
      .clk(clk), .rstn(rstn), .hsel(hsel), .hwrite(hwrite), .haddr(haddr),
      .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata),
      .rx_pin(rx_pin), .tx_pin(tx_pin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus transfer; lat counts edges from the command edge to the DONE cycle.
   task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int unsigned max_wait, output logic [31:0] rd,
                      output logic rs, output int unsigned lat);
      @(negedge clk);
      hsel = 1'b1; hwrite = wr; haddr = $urandom; hwdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      hsel = 1'b0; hwrite = 1'($urandom); haddr = addr;
      @(posedge clk);
      @(negedge clk);
      hwdata = data; haddr = $urandom;
      lat = 2;
      while (hready !== 1'b1 && lat < max_wait) begin
         @(negedge clk);
         lat++;
      end
      rd = hrdata;
      rs = hresp;
      chk("bus_done", 32'(hready), 32'd1);
   endtask

   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int unsigned extra, input string tag);
      logic [31:0] rd, exp_rd;
      logic        rs, exp_rs;
      int unsigned lat, exp_lat;
      logic [3:0]  sel;
      sel     = addr[31:28];
      exp_rs  = !(sel == 4'h7 || sel == 4'h3);
      exp_lat = (exp_rs || (sel == 4'h7 && !wr)) ? 2 : 3 + extra;
      exp_rd  = model_hrdata;
      if (!exp_rs && !wr) exp_rd = (sel == 4'h7) ? {31'b0, model_scanf} : model_last_rx;
      bus(wr, addr, data, 20 + extra, rd, rs, lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_resp"}, 32'(rs), 32'(exp_rs));
      chk({tag, "_rdata"}, rd, exp_rd);
      model_hrdata = exp_rd;
      if (!exp_rs && wr && sel == 4'h7) model_scanf = data[0];
   endtask

   // Called at the first negedge of the start bit.
   task automatic check_frame(input logic [31:0] word, input string tag);
      for (int k = 0; k < 34; k++) begin
         logic        expb;
         int unsigned bad;
         bad  = 0;
         expb = (k == 0) ? 1'b0 : (k == 33) ? 1'b1 : word[k-1];
         for (int c = 0; c < int'(CYCLE); c++) begin
            if (tx_pin !== expb) bad++;
            @(negedge clk);
         end
         chk($sformatf("%s_bit%0d", tag, k), bad, 0);
      end
      chk({tag, "_idle"}, 32'(tx_pin), 32'd1);
   endtask

   task automatic drive_rx(input logic [31:0] word, input logic stop, input logic timing);
      int unsigned done_n;
      done_n = 33 * CYCLE + HALF + 2;
      for (int unsigned n = 0; n < FRAME; n++) begin
         int unsigned j;
         @(negedge clk);
         if (timing && n == done_n - 1) chk("rx_not_early", 32'(hready), 32'd0);
         if (timing && n == done_n)     chk("rx_ready", 32'(hready), 32'd1);
         j = n / CYCLE;
         rx_pin = (j == 0) ? 1'b0 : (j == 33) ? stop : word[j-1];
      end
      @(negedge clk);
      rx_pin = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx_pin", 32'(tx_pin), 32'd1);
      chk("rst_hready", 32'(hready), 32'd1);
      chk("rst_hresp",  32'(hresp),  32'd0);
      chk("rst_hrdata", hrdata, 32'd0);
      rstn = 1'b0;

      // hsel low: no transaction
      @(negedge clk);
      hsel = 1'b0; hwrite = 1'b1; haddr = 32'hF0F0F0F0; hwdata = 32'h12345678;
      repeat (6) @(negedge clk);
      chk("inv_tx_pin", 32'(tx_pin), 32'd1);
      chk("inv_hready", 32'(hready), 32'd1);
      do_access(1'b0, 32'h70F0F0F0, 32'h0, 0, "inv_ctrl_rd");

      // CTRL register
      do_access(1'b1, 32'h70F0F0F0, 32'h1234567F, 0, "ctrl_set");
      do_access(1'b0, 32'h70F0F0F0, 32'h0, 0, "ctrl_rd1");
      do_access(1'b1, 32'h70F0F0F0, 32'h12345670, 0, "ctrl_clr");
      do_access(1'b0, 32'h70F0F0F0, 32'h0, 0, "ctrl_rd0");
      for (int i = 0; i < 3; i++) begin
         do_access(1'b1, {4'h7, 28'($urandom)}, $urandom, 0, "ctrl_rnd_wr");
         do_access(1'b0, {4'h7, 28'($urandom)}, 32'h0, 0, "ctrl_rnd_rd");
      end

      // Unmapped accesses leave registers and hrdata alone
      do_access(1'b1, 32'h70000000, 32'h0000007F, 0, "pre_unm_set");
      do_access(1'b0, 32'h70000000, 32'h0, 0, "pre_unm_rd");
      do_access(1'b1, 32'h50000000, 32'h12345670, 0, "unm_wr");
      @(negedge clk);
      chk("unm_resp_clear", 32'(hresp), 32'd0);
      do_access(1'b0, {4'hA, 28'($urandom)}, 32'h0, 0, "unm_rd");
      do_access(1'b0, 32'h70000000, 32'h0, 0, "post_unm_rd");
      do_access(1'b1, 32'h70000000, 32'h00000070, 0, "scanf_off");

      // Transmit
      do_access(1'b1, 32'h30F0F0F0, 32'h12345678, 0, "tx_wr");
      check_frame(32'h12345678, "tx0");
      w_a = $urandom;
      w_b = $urandom;
      do_access(1'b1, {4'h3, 28'($urandom)}, w_a, 0, "tx_a");
      // B is issued two edges after A completes and waits for A's whole frame.
      do_access(1'b1, {4'h3, 28'($urandom)}, w_b, FRAME - 3, "tx_b");
      check_frame(w_b, "txb");

      // Receive with scanf set
      do_access(1'b1, {4'h7, 28'($urandom)}, 32'hABCDEF7F, 0, "rx_scanf_on");
      fork
         bus(1'b0, 32'h30F0F0F0, 32'h0, 4 * FRAME, rx_rd, rx_rs, rx_lat);
         begin
            repeat (6) @(negedge clk);
            drive_rx(32'hF6CCAAE7, 1'b1, 1'b1);
         end
      join
      chk("rx1_data", rx_rd, 32'hF6CCAAE7);
      chk("rx1_resp", 32'(rx_rs), 32'd0);
      model_last_rx = 32'hF6CCAAE7;
      model_hrdata  = 32'hF6CCAAE7;

      // Glitch and framing error are skipped; the next good frame is returned.
      w_rx2 = $urandom;
      fork
         bus(1'b0, {4'h3, 28'($urandom)}, 32'h0, 4 * FRAME, rx_rd, rx_rs, rx_lat);
         begin
            repeat (6) @(negedge clk);
            rx_pin = 1'b0;
            repeat (2) @(negedge clk);
            rx_pin = 1'b1;
            repeat (2 * CYCLE) @(negedge clk);
            drive_rx(~w_rx2, 1'b0, 1'b0);
            repeat (CYCLE) @(negedge clk);
            drive_rx(w_rx2, 1'b1, 1'b0);
         end
      join
      chk("rx2_data", rx_rd, w_rx2);
      model_last_rx = w_rx2;
      model_hrdata  = w_rx2;

      do_access(1'b1, 32'h70F0F0F0, 32'h12345670, 0, "rx_scanf_off");
      do_access(1'b0, 32'h70F0F0F0, 32'h0, 0, "rx_ctrl_rd0");
      do_access(1'b0, 32'h30F0F0F0, 32'h0, 0, "rx_last_word");

      // Reset in the middle of a frame
      do_access(1'b1, 32'h70F0F0F0, 32'h0000007F, 0, "rst_pre_scanf");
      do_access(1'b1, 32'h30F0F0F0, 32'h0000FFFF, 0, "rst_tx");
      repeat (5 * CYCLE) @(negedge clk);
      #2 rstn = 1'b1;
      #1;
      chk("midrst_tx_pin", 32'(tx_pin), 32'd1);
      chk("midrst_hready", 32'(hready), 32'd1);
      chk("midrst_hrdata", hrdata, 32'd0);
      model_scanf = 1'b0; model_last_rx = '0; model_hrdata = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      do_access(1'b0, 32'h70F0F0F0, 32'h0, 0, "postrst_ctrl");
      do_access(1'b0, 32'h30F0F0F0, 32'h0, 0, "postrst_data");
      w_a = $urandom;
      do_access(1'b1, 32'h30F0F0F0, w_a, 0, "postrst_tx");
      check_frame(w_a, "txr");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
